// File: rtl/pic_inta_sequencer_if.sv
// Bundles the resolver, register, cascade and CPU-side signals of the INTA sequencer.
interface pic_inta_sequencer_if #(
  parameter int NUM_IRQ   = 8,
  parameter int CAS_WIDTH = 3
);
  localparam int IDXW = $clog2(NUM_IRQ);

  logic                 INTA_n;
  logic                 irq_pending;
  logic [IDXW-1:0]      irq_index;
  logic                 mode_8086;
  logic                 SP;
  logic [NUM_IRQ-1:0]   ICW3;
  logic [CAS_WIDTH-1:0] CAS_in;
  logic                 aeoi;
  logic [7:0]           vector_base;
  logic [7:0]           addr_hi;
  logic                 write_flag;
  logic                 read_cmd;
  logic [7:0]           OCW3;

  logic                 INT;
  logic                 freeze;
  logic                 isr_set;
  logic [IDXW-1:0]      isr_index;
  logic                 eoi_pulse;
  logic [7:0]           data_out;
  logic                 data_oe;
  logic [CAS_WIDTH-1:0] CAS_out;
  logic                 cas_drive;
  logic                 read_IRR;
  logic                 read_ISR;

  modport master (
    output INTA_n, irq_pending, irq_index, mode_8086, SP, ICW3, CAS_in, aeoi,
           vector_base, addr_hi, write_flag, read_cmd, OCW3,
    input  INT, freeze, isr_set, isr_index, eoi_pulse, data_out, data_oe,
           CAS_out, cas_drive, read_IRR, read_ISR
  );

  modport slave (
    input  INTA_n, irq_pending, irq_index, mode_8086, SP, ICW3, CAS_in, aeoi,
           vector_base, addr_hi, write_flag, read_cmd, OCW3,
    output INT, freeze, isr_set, isr_index, eoi_pulse, data_out, data_oe,
           CAS_out, cas_drive, read_IRR, read_ISR
  );
endinterface

// File: rtl/pic_inta_sequencer.sv
// PIC interrupt-acknowledge sequencer: raises INT, walks the 8086/8080 INTA pulses,
// drives vector bytes and cascade ID; all outputs registered, one clock after edge detect.
module pic_inta_sequencer #(
  parameter int NUM_IRQ   = 8,
  parameter int CAS_WIDTH = 3
) (
  input logic clk,
  input logic rst,
  pic_inta_sequencer_if.slave bus
);
  localparam int IDXW = $clog2(NUM_IRQ);
  localparam logic [IDXW-1:0] SPURIOUS_IDX = IDXW'(NUM_IRQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_P1, S_P2, S_P3, S_SKIP} state_t;

  state_t               r_state, w_nxt_state;
  logic                 r_inta_q;
  logic                 r_read_q;
  logic [IDXW-1:0]      r_idx, w_nxt_idx;
  logic                 r_pend, w_nxt_pend;
  logic                 r_suppress, w_nxt_suppress;
  logic [1:0]           r_skip_cnt, w_nxt_skip_cnt;

  logic                 r_int, w_nxt_int;
  logic                 r_freeze, w_nxt_freeze;
  logic                 r_isr_set, w_nxt_isr_set;
  logic [IDXW-1:0]      r_isr_index, w_nxt_isr_index;
  logic                 r_eoi, w_nxt_eoi;
  logic [7:0]           r_data_out, w_nxt_data_out;
  logic                 r_data_oe, w_nxt_data_oe;
  logic [CAS_WIDTH-1:0] r_cas_out, w_nxt_cas_out;
  logic                 r_cas_drive, w_nxt_cas_drive;
  logic                 r_read_irr, w_nxt_read_irr;
  logic                 r_read_isr, w_nxt_read_isr;

  logic                 w_fall, w_rise, w_ack_start, w_qualify;
  logic [IDXW-1:0]      w_req_idx;
  logic                 w_req_pend, w_slave_on_idx, w_cas_match;
  logic [7:0]           w_vector;

  assign w_fall      = r_inta_q & ~bus.INTA_n;
  assign w_rise      = ~r_inta_q & bus.INTA_n;
  assign w_qualify   = bus.irq_pending & ~bus.write_flag & ~bus.read_cmd;
  assign w_ack_start = w_fall & ((r_state == S_IDLE) | (r_state == S_REQ));

  // An acknowledge that arrives without INT raised always resolves to the spurious line.
  assign w_req_pend     = (r_state == S_REQ) & bus.irq_pending;
  assign w_req_idx      = w_req_pend ? bus.irq_index : SPURIOUS_IDX;
  assign w_slave_on_idx = bus.SP & bus.ICW3[w_req_idx];
  assign w_cas_match    = (bus.CAS_in == bus.ICW3[CAS_WIDTH-1:0]);
  assign w_vector       = {bus.vector_base[7:IDXW], r_idx};

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_idx       = r_idx;
    w_nxt_pend      = r_pend;
    w_nxt_suppress  = r_suppress;
    w_nxt_skip_cnt  = r_skip_cnt;
    w_nxt_int       = r_int;
    w_nxt_freeze    = r_freeze;
    w_nxt_isr_set   = 1'b0;
    w_nxt_isr_index = r_isr_index;
    w_nxt_eoi       = 1'b0;
    w_nxt_data_out  = r_data_out;
    w_nxt_data_oe   = r_data_oe;
    w_nxt_cas_out   = r_cas_out;
    w_nxt_cas_drive = r_cas_drive;
    w_nxt_read_irr  = r_read_irr;
    w_nxt_read_isr  = r_read_isr;

    if (w_ack_start) begin
      w_nxt_state    = S_P1;
      w_nxt_int      = 1'b0;
      w_nxt_freeze   = 1'b1;
      w_nxt_idx      = w_req_idx;
      w_nxt_pend     = w_req_pend;
      w_nxt_suppress = w_slave_on_idx;
      if (bus.SP && w_req_pend) begin
        w_nxt_isr_set   = 1'b1;
        w_nxt_isr_index = w_req_idx;
      end
      if (w_slave_on_idx) begin
        w_nxt_cas_out   = CAS_WIDTH'(w_req_idx);
        w_nxt_cas_drive = 1'b1;
      end
      if (!bus.mode_8086) begin
        w_nxt_data_out = 8'hCD;
        w_nxt_data_oe  = 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_int = w_qualify;
          if (w_qualify) w_nxt_state = S_REQ;
        end
        S_REQ: ;
        S_P1: begin
          if (w_rise) begin
            w_nxt_data_oe = 1'b0;
            if (!bus.SP && !w_cas_match) begin
              w_nxt_state    = S_SKIP;
              w_nxt_freeze   = 1'b0;
              w_nxt_int      = bus.irq_pending;
              w_nxt_skip_cnt = bus.mode_8086 ? 2'd1 : 2'd2;
            end else begin
              w_nxt_state = S_P2;
              if (!bus.SP && r_pend) begin
                w_nxt_isr_set   = 1'b1;
                w_nxt_isr_index = r_idx;
              end
            end
          end
        end
        S_P2, S_P3: begin
          if (w_fall) begin
            w_nxt_data_out = (r_state == S_P2) ? w_vector : bus.addr_hi;
            w_nxt_data_oe  = ~r_suppress;
          end else if (w_rise) begin
            w_nxt_data_oe = 1'b0;
            if (r_state == S_P2 && !bus.mode_8086) begin
              w_nxt_state = S_P3;
            end else begin
              w_nxt_state     = S_IDLE;
              w_nxt_cas_drive = 1'b0;
              w_nxt_freeze    = 1'b0;
              if (bus.aeoi) begin
                w_nxt_eoi       = 1'b1;
                w_nxt_isr_index = r_idx;
              end
            end
          end
        end
        S_SKIP: begin
          if (w_rise) begin
            w_nxt_skip_cnt = r_skip_cnt - 2'd1;
            if (r_skip_cnt == 2'd1) w_nxt_state = S_IDLE;
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end

    // Status select changes only on a fresh read strobe; OCW3[1]=0 leaves it untouched.
    if (bus.read_cmd && !r_read_q && bus.OCW3[1]) begin
      w_nxt_read_irr = ~bus.OCW3[0];
      w_nxt_read_isr = bus.OCW3[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_inta_q    <= 1'b1;
      r_read_q    <= 1'b0;
      r_idx       <= '0;
      r_pend      <= 1'b0;
      r_suppress  <= 1'b0;
      r_skip_cnt  <= '0;
      r_int       <= 1'b0;
      r_freeze    <= 1'b0;
      r_isr_set   <= 1'b0;
      r_isr_index <= '0;
      r_eoi       <= 1'b0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
      r_cas_out   <= '0;
      r_cas_drive <= 1'b0;
      r_read_irr  <= 1'b0;
      r_read_isr  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_inta_q    <= bus.INTA_n;
      r_read_q    <= bus.read_cmd;
      r_idx       <= w_nxt_idx;
      r_pend      <= w_nxt_pend;
      r_suppress  <= w_nxt_suppress;
      r_skip_cnt  <= w_nxt_skip_cnt;
      r_int       <= w_nxt_int;
      r_freeze    <= w_nxt_freeze;
      r_isr_set   <= w_nxt_isr_set;
      r_isr_index <= w_nxt_isr_index;
      r_eoi       <= w_nxt_eoi;
      r_data_out  <= w_nxt_data_out;
      r_data_oe   <= w_nxt_data_oe;
      r_cas_out   <= w_nxt_cas_out;
      r_cas_drive <= w_nxt_cas_drive;
      r_read_irr  <= w_nxt_read_irr;
      r_read_isr  <= w_nxt_read_isr;
    end
  end

  assign bus.INT       = r_int;
  assign bus.freeze    = r_freeze;
  assign bus.isr_set   = r_isr_set;
  assign bus.isr_index = r_isr_index;
  assign bus.eoi_pulse = r_eoi;
  assign bus.data_out  = r_data_out;
  assign bus.data_oe   = r_data_oe;
  assign bus.CAS_out   = r_cas_out;
  assign bus.cas_drive = r_cas_drive;
  assign bus.read_IRR  = r_read_irr;
  assign bus.read_ISR  = r_read_isr;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: 8086/8080 acknowledge, cascade master/slave,
// spurious acknowledge, mid-sequence reset and status-read select.
module tb_pic_inta_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pic_inta_sequencer_if #(.NUM_IRQ(8), .CAS_WIDTH(3)) bus ();

  pic_inta_sequencer #(.NUM_IRQ(8), .CAS_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inta(input logic v);
    bus.INTA_n = v;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.INTA_n      = 1'b1;
    bus.irq_pending = 1'b0;
    bus.irq_index   = 3'd0;
    bus.mode_8086   = 1'b1;
    bus.SP          = 1'b1;
    bus.ICW3        = 8'h00;
    bus.CAS_in      = 3'd0;
    bus.aeoi        = 1'b0;
    bus.vector_base = 8'h40;
    bus.addr_hi     = 8'h00;
    bus.write_flag  = 1'b0;
    bus.read_cmd    = 1'b0;
    bus.OCW3        = 8'h00;

    // Reset state
    tick();
    tick();
    expect_eq("rst_int", bus.INT, 1'b0);
    expect_eq("rst_freeze", bus.freeze, 1'b0);
    expect_eq("rst_oe", bus.data_oe, 1'b0);
    rst = 1'b0;

    // 8086 master, IR3, base 0x40
    bus.irq_pending = 1'b1;
    bus.irq_index   = 3'd3;
    tick();
    expect_eq("t1_int", bus.INT, 1'b1);
    bus.write_flag = 1'b1;
    tick();
    expect_eq("t1_int_hold_wr", bus.INT, 1'b1);
    bus.write_flag = 1'b0;
    inta(1'b0);
    expect_eq("t1_int_drop", bus.INT, 1'b0);
    expect_eq("t1_freeze", bus.freeze, 1'b1);
    expect_eq("t1_isr_set", bus.isr_set, 1'b1);
    expect_eq("t1_isr_idx", bus.isr_index, 3'd3);
    expect_eq("t1_oe_p1", bus.data_oe, 1'b0);
    bus.irq_pending = 1'b0;
    bus.irq_index   = 3'd6;
    tick();
    expect_eq("t1_isr_set_1cyc", bus.isr_set, 1'b0);
    inta(1'b1);
    expect_eq("t1_oe_p1r", bus.data_oe, 1'b0);
    inta(1'b0);
    expect_eq("t1_vec", bus.data_out, 8'h43);
    expect_eq("t1_oe_p2", bus.data_oe, 1'b1);
    inta(1'b1);
    expect_eq("t1_oe_end", bus.data_oe, 1'b0);
    expect_eq("t1_freeze_end", bus.freeze, 1'b0);
    expect_eq("t1_no_eoi", bus.eoi_pulse, 1'b0);
    tick();
    expect_eq("t1_no_eoi2", bus.eoi_pulse, 1'b0);

    // 8080, auto-EOI, IR5, base 0x20, addr_hi 0x12
    bus.mode_8086   = 1'b0;
    bus.aeoi        = 1'b1;
    bus.vector_base = 8'h20;
    bus.addr_hi     = 8'h12;
    bus.irq_index   = 3'd5;
    bus.irq_pending = 1'b1;
    tick();
    inta(1'b0);
    expect_eq("t2_call", bus.data_out, 8'hCD);
    expect_eq("t2_oe1", bus.data_oe, 1'b1);
    expect_eq("t2_isr_set", bus.isr_set, 1'b1);
    bus.irq_pending = 1'b0;
    inta(1'b1);
    expect_eq("t2_oe1_off", bus.data_oe, 1'b0);
    inta(1'b0);
    expect_eq("t2_vec", bus.data_out, 8'h25);
    inta(1'b1);
    inta(1'b0);
    expect_eq("t2_addr_hi", bus.data_out, 8'h12);
    expect_eq("t2_oe3", bus.data_oe, 1'b1);
    inta(1'b1);
    expect_eq("t2_eoi", bus.eoi_pulse, 1'b1);
    expect_eq("t2_eoi_idx", bus.isr_index, 3'd5);
    tick();
    expect_eq("t2_eoi_1cyc", bus.eoi_pulse, 1'b0);

    // Master with a slave on IR2
    bus.mode_8086   = 1'b1;
    bus.aeoi        = 1'b0;
    bus.vector_base = 8'h40;
    bus.ICW3        = 8'h04;
    bus.irq_index   = 3'd2;
    bus.irq_pending = 1'b1;
    tick();
    inta(1'b0);
    expect_eq("t3_cas_drive", bus.cas_drive, 1'b1);
    expect_eq("t3_cas_out", bus.CAS_out, 3'd2);
    bus.irq_pending = 1'b0;
    inta(1'b1);
    inta(1'b0);
    expect_eq("t3_oe_supp", bus.data_oe, 1'b0);
    expect_eq("t3_cas_hold", bus.cas_drive, 1'b1);
    inta(1'b1);
    expect_eq("t3_cas_end", bus.cas_drive, 1'b0);

    // Slave ID 3, matched
    bus.SP          = 1'b0;
    bus.ICW3        = 8'h03;
    bus.CAS_in      = 3'd3;
    bus.irq_index   = 3'd1;
    bus.irq_pending = 1'b1;
    tick();
    inta(1'b0);
    expect_eq("t4_no_early_set", bus.isr_set, 1'b0);
    bus.irq_pending = 1'b0;
    inta(1'b1);
    expect_eq("t4_isr_set", bus.isr_set, 1'b1);
    expect_eq("t4_isr_idx", bus.isr_index, 3'd1);
    inta(1'b0);
    expect_eq("t4_vec", bus.data_out, 8'h41);
    expect_eq("t4_oe", bus.data_oe, 1'b1);
    inta(1'b1);

    // Slave ID 3, cascade bus carries 1
    bus.CAS_in      = 3'd1;
    bus.irq_pending = 1'b1;
    tick();
    inta(1'b0);
    bus.irq_pending = 1'b0;
    inta(1'b1);
    expect_eq("t4s_no_set", bus.isr_set, 1'b0);
    expect_eq("t4s_freeze", bus.freeze, 1'b0);
    inta(1'b0);
    expect_eq("t4s_oe", bus.data_oe, 1'b0);
    inta(1'b1);
    bus.irq_pending = 1'b1;
    tick();
    expect_eq("t4s_back_idle", bus.INT, 1'b1);
    bus.irq_pending = 1'b0;
    do_reset();

    // Acknowledge with nothing pending
    bus.SP   = 1'b1;
    bus.ICW3 = 8'h00;
    inta(1'b0);
    expect_eq("t5_no_set", bus.isr_set, 1'b0);
    expect_eq("t5_freeze", bus.freeze, 1'b1);
    inta(1'b1);
    inta(1'b0);
    expect_eq("t5_vec", bus.data_out, 8'h47);
    inta(1'b1);

    // Reset during pulse 2
    bus.irq_index   = 3'd3;
    bus.irq_pending = 1'b1;
    tick();
    inta(1'b0);
    bus.irq_pending = 1'b0;
    inta(1'b1);
    inta(1'b0);
    expect_eq("t6_pre_oe", bus.data_oe, 1'b1);
    rst        = 1'b1;
    bus.INTA_n = 1'b1;
    tick();
    expect_eq("t6_oe", bus.data_oe, 1'b0);
    expect_eq("t6_data", bus.data_out, 8'h00);
    expect_eq("t6_freeze", bus.freeze, 1'b0);
    expect_eq("t6_isr_idx", bus.isr_index, 3'd0);
    expect_eq("t6_misc", {bus.INT, bus.isr_set, bus.eoi_pulse, bus.cas_drive,
                          bus.read_IRR, bus.read_ISR, bus.CAS_out}, 9'd0);
    rst = 1'b0;

    // Status read select
    bus.OCW3     = 8'h0B;
    bus.read_cmd = 1'b1;
    tick();
    expect_eq("t7_isr", bus.read_ISR, 1'b1);
    expect_eq("t7_irr", bus.read_IRR, 1'b0);
    bus.read_cmd = 1'b0;
    bus.OCW3     = 8'h0A;
    tick();
    bus.read_cmd = 1'b1;
    tick();
    expect_eq("t7_irr2", bus.read_IRR, 1'b1);
    expect_eq("t7_isr2", bus.read_ISR, 1'b0);
    bus.read_cmd = 1'b0;
    bus.OCW3     = 8'h08;
    tick();
    bus.read_cmd = 1'b1;
    tick();
    expect_eq("t7_irr_keep", bus.read_IRR, 1'b1);
    bus.read_cmd = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
